// File: rtl/cordic_pkg.sv
// cordic_pkg: shared ALU op codes, FSM states and CORDIC gain for the vectoring engine.
package cordic_pkg;
  typedef enum logic [1:0] {ADD = 2'd0, SUB = 2'd1, NOP = 2'd2} alu_op_e;
  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_e;
  localparam real CORDIC_GAIN = 1.6467602581;
endpackage

// File: rtl/cordic_vector_iter_if.sv
// cordic_vector_iter_if: operand/result handshake between source, engine and consumer.
interface cordic_vector_iter_if #(
  parameter int WORD_WIDTH  = 16,
  parameter int ANGLE_WIDTH = 16
);
  logic start;
  logic busy;
  logic out_valid;
  logic signed [WORD_WIDTH-1:0] x_in;
  logic signed [WORD_WIDTH-1:0] y_in;
  logic signed [WORD_WIDTH+1:0] magnitude;
  logic signed [ANGLE_WIDTH-1:0] angle;
  modport master (output start, x_in, y_in, input busy, out_valid, magnitude, angle);
  modport slave (input start, x_in, y_in, output busy, out_valid, magnitude, angle);
endinterface

// File: rtl/cordic_alu.sv
// cordic_alu: signed add/sub datapath shared by the x, y and z updates.
module cordic_alu import cordic_pkg::*; #(
  parameter int WORD_WIDTH = 16
) (
  input  alu_op_e                      op_i,
  input  logic signed [WORD_WIDTH-1:0] a_i,
  input  logic signed [WORD_WIDTH-1:0] b_i,
  output logic signed [WORD_WIDTH-1:0] y_o
);
  assign y_o = op_i == ADD ? a_i + b_i : op_i == SUB ? a_i - b_i : a_i;
endmodule

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom: atan(2^-i) as a binary angle, rounded from a 32-bit master table.
module cordic_atan_rom #(
  parameter int ANGLE_WIDTH = 16,
  localparam int IW = $clog2(ANGLE_WIDTH)
) (
  input  logic [IW-1:0]          iter_i,
  output logic [ANGLE_WIDTH-1:0] atan_o
);
  localparam int SH = 32 - ANGLE_WIDTH;
  localparam logic [32:0] HALF = (33'd1 << SH) >> 1;
  localparam logic [31:0] TABLE [30] = '{
    32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756, 32'd42667331,
    32'd21354465,  32'd10679838,  32'd5340245,   32'd2670163,  32'd1335087,
    32'd667544,    32'd333772,    32'd166886,    32'd83443,    32'd41722,
    32'd20861,     32'd10430,     32'd5215,      32'd2608,     32'd1304,
    32'd652,       32'd326,       32'd163,       32'd81,       32'd41,
    32'd20,        32'd10,        32'd5,         32'd3,        32'd1
  };
  logic [32:0] sum;
  assign sum    = {1'b0, TABLE[iter_i]} + HALF;
  assign atan_o = ANGLE_WIDTH'(sum >> SH);
endmodule

// File: rtl/cordic_vector_iter.sv
// cordic_vector_iter: iterative CORDIC vectoring engine, one micro-rotation per clock.
module cordic_vector_iter import cordic_pkg::*; #(
  parameter int WORD_WIDTH  = 16,
  parameter int ANGLE_WIDTH = 16,
  parameter int ITERATIONS  = 14
) (
  input logic clk,
  input logic rst,
  cordic_vector_iter_if.slave bus
);
  localparam int GW = WORD_WIDTH + 2;
  localparam int IW = $clog2(ANGLE_WIDTH);
  localparam logic [ANGLE_WIDTH-1:0] QUARTER = ANGLE_WIDTH'(1) << (ANGLE_WIDTH - 2);
  state_e state_q, state_d;
  logic [IW-1:0] iter_q, iter_d;
  logic signed [GW-1:0] x_q, x_d, y_q, y_d, mag_q, mag_d, xs, ys, x_nx, y_nx;
  logic signed [ANGLE_WIDTH-1:0] z_q, z_d, ang_q, ang_d, z_nx;
  logic [ANGLE_WIDTH-1:0] atan;
  logic down;
  alu_op_e op_xz, op_y;
  assign xs    = GW'(bus.x_in);
  assign ys    = GW'(bus.y_in);
  assign down  = y_q[GW-1];
  assign op_xz = down ? SUB : ADD;
  assign op_y  = down ? ADD : SUB;
  cordic_atan_rom #(.ANGLE_WIDTH(ANGLE_WIDTH)) u_rom (.iter_i(iter_q), .atan_o(atan));
  cordic_alu #(.WORD_WIDTH(GW)) u_alu_x (.op_i(op_xz), .a_i(x_q), .b_i(y_q >>> iter_q), .y_o(x_nx));
  cordic_alu #(.WORD_WIDTH(GW)) u_alu_y (.op_i(op_y), .a_i(y_q), .b_i(x_q >>> iter_q), .y_o(y_nx));
  cordic_alu #(.WORD_WIDTH(ANGLE_WIDTH)) u_alu_z (.op_i(op_xz), .a_i(z_q), .b_i(atan), .y_o(z_nx));
  // Pre-rotation by +/-90 deg puts the vector in the right half-plane, where CORDIC converges.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    mag_d   = mag_q;
    ang_d   = ang_q;
    if (state_q == IDLE && bus.start) begin
      state_d = ROTATE;
      iter_d  = '0;
      x_d     = !xs[GW-1] ? xs : !ys[GW-1] ? ys : -ys;
      y_d     = !xs[GW-1] ? ys : !ys[GW-1] ? -xs : xs;
      z_d     = !xs[GW-1] ? '0 : !ys[GW-1] ? QUARTER : -QUARTER;
    end else if (state_q == ROTATE) begin
      x_d    = x_nx;
      y_d    = y_nx;
      z_d    = z_nx;
      iter_d = iter_q + 1'b1;
      if (iter_q == IW'(ITERATIONS - 1)) begin
        state_d = DONE;
        mag_d   = x_nx;
        ang_d   = z_nx;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      iter_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mag_q   <= '0;
      ang_q   <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      mag_q   <= mag_d;
      ang_q   <= ang_d;
    end
  end
  assign bus.busy      = state_q != IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.magnitude = mag_q;
  assign bus.angle     = ang_q;
endmodule

// File: tb/tb_cordic_vector_iter.sv
// tb_cordic_vector_iter: random and directed vectors against an ideal polar-form reference.
module tb_cordic_vector_iter;
  import cordic_pkg::*;
  localparam int WW = 16;
  localparam int AW = 16;
  localparam int IT = 14;
  localparam real PI = 3.14159265358979;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  cordic_vector_iter_if #(.WORD_WIDTH(WW), .ANGLE_WIDTH(AW)) bus ();
  cordic_vector_iter #(.WORD_WIDTH(WW), .ANGLE_WIDTH(AW), .ITERATIONS(IT)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp, input longint tol);
    n_cmp++;
    if (obs > exp + tol || obs < exp - tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  // Ideal K*|v| and atan2; tolerance allows for truncation of the arithmetic shifts.
  task automatic check_result(input string tag, input int x, input int y);
    real m = CORDIC_GAIN * $sqrt(real'(x) * x + real'(y) * y);
    real a = $atan2(real'(y), real'(x)) * 65536.0 / (2.0 * PI);
    real e = real'(bus.angle) - a;
    chk({tag, ".mag"}, longint'(bus.magnitude), longint'(m), 2 + IT + longint'(m * 0.002));
    chk({tag, ".sign"}, longint'(bus.magnitude[WW+1]), 0, 0);
    if (x != 0 || y != 0) begin
      while (e > 32768.0) e -= 65536.0;
      while (e < -32768.0) e += 65536.0;
      chk({tag, ".ang"}, longint'(a + e), longint'(a), IT);
    end
  endtask

  task automatic run_op(input string tag, input int x, input int y);
    int n = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.x_in  = WW'(x);
    bus.y_in  = WW'(y);
    @(posedge clk);
    #1 bus.start = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk({tag, ".busy"}, longint'(bus.busy), 1, 0);
    end while (!bus.out_valid && n < 40);
    chk({tag, ".lat"}, n, IT + 1, 0);
    check_result(tag, x, y);
    @(negedge clk);
    chk({tag, ".idle"}, longint'({bus.busy, bus.out_valid}), 0, 0);
  endtask

  int dx [9] = '{100, 0, 100, -100, -100, -32768, 0, 32767, -32768};
  int dy [9] = '{0, 100, 100, 0, -100, -32768, 0, -32768, 32767};

  initial begin
    int pulses, first, second, mx, rx, ry;
    bus.start = 1'b0;
    bus.x_in  = '0;
    bus.y_in  = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", longint'(bus.busy), 0, 0);
    chk("rst.valid", longint'(bus.out_valid), 0, 0);
    chk("rst.mag", longint'(bus.magnitude), 0, 0);
    chk("rst.ang", longint'(bus.angle), 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) run_op($sformatf("dir%0d", i), dx[i], dy[i]);
    for (int i = 0; i < 20; i++) begin
      mx = int'($urandom_range(32767, 4096));
      rx = $urandom_range(1) ? -mx : mx;
      ry = int'($urandom_range(65535)) - 32768;
      if ($urandom_range(1)) begin
        mx = rx;
        rx = ry;
        ry = mx;
      end
      run_op($sformatf("rnd%0d", i), rx, ry);
    end
    // start during ROTATE (cycle 3) and DONE (cycle 15) must be ignored
    pulses = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.x_in  = 16'sd300;
    bus.y_in  = -16'sd200;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        pulses++;
        chk("ign.when", n, IT + 1, 0);
      end
      bus.start = (n == 3 || n == 15);
    end
    bus.start = 1'b0;
    chk("ign.pulses", pulses, 1, 0);
    // start held high: back-to-back with one idle cycle between operations
    first  = -1;
    second = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.x_in  = -16'sd5000;
    bus.y_in  = 16'sd7000;
    for (int n = 1; n <= 60 && second < 0; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (first < 0) first = n;
        else begin
          second = n;
          bus.start = 1'b0;
          check_result("held2", -5000, 7000);
        end
      end
    end
    bus.start = 1'b0;
    chk("held.first", first, IT + 1, 0);
    chk("held.gap", second - first, IT + 2, 0);
    repeat (3) @(negedge clk);
    chk("held.stop", longint'(bus.busy), 0, 0);
    // reset mid-operation aborts with no result
    @(negedge clk);
    bus.start = 1'b1;
    bus.x_in  = 16'sd12000;
    bus.y_in  = 16'sd5000;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort.busy", longint'(bus.busy), 0, 0);
    chk("abort.valid", longint'(bus.out_valid), 0, 0);
    chk("abort.mag", longint'(bus.magnitude), 0, 0);
    chk("abort.ang", longint'(bus.angle), 0, 0);
    rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
    end
    chk("abort.stray", pulses, 0, 0);
    run_op("post_rst", 12000, 5000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
